// File: rtl/fe_pkg.sv
// =============================================================================
// Module      : fe_pkg
// Description : Front-end shared constants and the packed decode-queue entry layout.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package fe_pkg;

    localparam int DQ_W     = 266;
    localparam int DQ_DEPTH = 4;

    // Field widths, listed MSB to LSB of the packed entry
    localparam int DQ_CS_W          = 62;
    localparam int DQ_IMM_W         = 32;
    localparam int DQ_DISP_W        = 32;
    localparam int DQ_IMMSIZE_W     = 2;
    localparam int DQ_DISPSIZE_W    = 2;
    localparam int DQ_SIB_W         = 1;
    localparam int DQ_SCALE_W       = 2;
    localparam int DQ_BASEREN_W     = 1;
    localparam int DQ_IDXREN_W      = 1;
    localparam int DQ_NEIP_W        = 32;
    localparam int DQ_EIP_W         = 32;
    localparam int DQ_BP_TGT_W      = 32;
    localparam int DQ_IMM8_W        = 8;
    localparam int DQ_OPSIZE_W      = 2;
    localparam int DQ_SR1_W         = 3;
    localparam int DQ_SR2_W         = 3;
    localparam int DQ_BASE_W        = 3;
    localparam int DQ_IDX_W         = 3;
    localparam int DQ_SEGR1_W       = 3;
    localparam int DQ_SEGR2_W       = 3;
    localparam int DQ_BP_TAKEN_W    = 1;
    localparam int DQ_INDIR_ADDR_W  = 1;
    localparam int DQ_DFLAG_W       = 1;
    localparam int DQ_BR_FETCH_ID_W = 4;

    // Field offsets, built upward from the LSB so the CS field lands at the top
    localparam int DQ_BR_FETCH_ID_LSB = 0;
    localparam int DQ_DFLAG_LSB       = DQ_BR_FETCH_ID_LSB + DQ_BR_FETCH_ID_W;
    localparam int DQ_INDIR_ADDR_LSB  = DQ_DFLAG_LSB       + DQ_DFLAG_W;
    localparam int DQ_BP_TAKEN_LSB    = DQ_INDIR_ADDR_LSB  + DQ_INDIR_ADDR_W;
    localparam int DQ_SEGR2_LSB       = DQ_BP_TAKEN_LSB    + DQ_BP_TAKEN_W;
    localparam int DQ_SEGR1_LSB       = DQ_SEGR2_LSB       + DQ_SEGR2_W;
    localparam int DQ_IDX_LSB         = DQ_SEGR1_LSB       + DQ_SEGR1_W;
    localparam int DQ_BASE_LSB        = DQ_IDX_LSB         + DQ_IDX_W;
    localparam int DQ_SR2_LSB         = DQ_BASE_LSB        + DQ_BASE_W;
    localparam int DQ_SR1_LSB         = DQ_SR2_LSB         + DQ_SR2_W;
    localparam int DQ_OPSIZE_LSB      = DQ_SR1_LSB         + DQ_SR1_W;
    localparam int DQ_IMM8_LSB        = DQ_OPSIZE_LSB      + DQ_OPSIZE_W;
    localparam int DQ_BP_TGT_LSB      = DQ_IMM8_LSB        + DQ_IMM8_W;
    localparam int DQ_EIP_LSB         = DQ_BP_TGT_LSB      + DQ_BP_TGT_W;
    localparam int DQ_NEIP_LSB        = DQ_EIP_LSB         + DQ_EIP_W;
    localparam int DQ_IDXREN_LSB      = DQ_NEIP_LSB        + DQ_NEIP_W;
    localparam int DQ_BASEREN_LSB     = DQ_IDXREN_LSB      + DQ_IDXREN_W;
    localparam int DQ_SCALE_LSB       = DQ_BASEREN_LSB     + DQ_BASEREN_W;
    localparam int DQ_SIB_LSB         = DQ_SCALE_LSB       + DQ_SCALE_W;
    localparam int DQ_DISPSIZE_LSB    = DQ_SIB_LSB         + DQ_SIB_W;
    localparam int DQ_IMMSIZE_LSB     = DQ_DISPSIZE_LSB    + DQ_DISPSIZE_W;
    localparam int DQ_DISP_LSB        = DQ_IMMSIZE_LSB     + DQ_IMMSIZE_W;
    localparam int DQ_IMM_LSB         = DQ_DISP_LSB        + DQ_DISP_W;
    localparam int DQ_CS_LSB          = DQ_IMM_LSB         + DQ_IMM_W;

    function automatic logic [DQ_CS_W-1:0] dq_get_cs(input logic [DQ_W-1:0] entry);
        return entry[DQ_CS_LSB +: DQ_CS_W];
    endfunction

endpackage

`default_nettype wire

// File: rtl/dq_ram.sv
// =============================================================================
// Module      : dq_ram
// Description : DEPTH x W storage, one write port, asynchronous read, no reset.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module dq_ram #(
    parameter int DEPTH = 4,
    parameter int W     = 266
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [W-1:0]             i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [W-1:0]             o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/decode_queue.sv
// =============================================================================
// Module      : decode_queue
// Description : Decoded-instruction FIFO between decode2 and register read.
//               Optional same-cycle bypass when empty: define DECODE_QUEUE_BYPASS_EN.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module decode_queue
    import fe_pkg::*;
#(
    parameter int DEPTH = DQ_DEPTH,
    parameter int W     = DQ_W
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     in_v,
    input  logic [W-1:0]             in_data,
    output logic                     dq_stall,
    input  logic                     rr_stall,
    output logic                     out_v,
    output logic [W-1:0]             out_data,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   dq_count
);

    localparam int              c_AW      = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_FULL    = (c_AW+1)'(DEPTH);
    localparam logic [c_AW:0]   c_CNT_ONE = (c_AW+1)'(1);
    localparam logic [c_AW-1:0] c_PTR_ONE = c_AW'(1);

    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic [W-1:0]    w_rdata;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;

    assign w_empty  = (r_count == '0);
    assign dq_stall = (r_count == c_FULL);
    assign dq_count = r_count;

`ifdef DECODE_QUEUE_BYPASS_EN
    logic w_bypass;

    // An empty queue forwards in_data straight out; it is only stored if RR holds.
    assign w_bypass = w_empty && in_v && !flush;
    assign out_v    = (!w_empty && !flush) || w_bypass;
    assign out_data = w_bypass ? in_data : w_rdata;
    assign w_pop    = !w_empty && !flush && !rr_stall;
    assign w_push   = in_v && !dq_stall && !flush && !(w_bypass && !rr_stall);
`else
    assign out_v    = !w_empty && !flush;
    assign out_data = w_rdata;
    assign w_pop    = out_v && !rr_stall;
    assign w_push   = in_v && !dq_stall && !flush;
`endif

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_ONE;
            end
        end
    end

    dq_ram #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_dq_ram (
        .clk     (CLK),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (in_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

endmodule

`default_nettype wire

// File: tb/tb_decode_queue.sv
// =============================================================================
// Module      : tb_decode_queue
// Description : Directed self-checking bench for decode_queue (DEPTH=4, W=266).
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_decode_queue;
    import fe_pkg::*;

    localparam int c_DEPTH = 4;
`ifdef DECODE_QUEUE_BYPASS_EN
    localparam int c_LAT = 0;
`else
    localparam int c_LAT = 1;
`endif

    logic            CLK = 1'b0;
    logic            reset = 1'b0;
    logic            in_v = 1'b0;
    logic [DQ_W-1:0] in_data = '0;
    logic            dq_stall;
    logic            rr_stall = 1'b0;
    logic            out_v;
    logic [DQ_W-1:0] out_data;
    logic            flush = 1'b0;
    logic [2:0]      dq_count;

    int checks = 0;
    int errors = 0;

    decode_queue #(.DEPTH(c_DEPTH), .W(DQ_W)) dut (
        .CLK      (CLK),
        .reset    (reset),
        .in_v     (in_v),
        .in_data  (in_data),
        .dq_stall (dq_stall),
        .rr_stall (rr_stall),
        .out_v    (out_v),
        .out_data (out_data),
        .flush    (flush),
        .dq_count (dq_count)
    );

    always #5 CLK = ~CLK;

    function automatic logic [DQ_W-1:0] mk(input int k);
        logic [31:0] v;
        v = 32'(k);
        return {v ^ 32'hA5A5_0000, 202'(0), v};
    endfunction

    task automatic check(input string tag, input logic [DQ_W-1:0] obs, input logic [DQ_W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Push n entries back to back with RR free; output must follow input c_LAT cycles later.
    task automatic stream(input int n, input int base);
        for (int k = 0; k <= n; k++) begin
            in_v    = (k < n);
            in_data = mk(base + k);
            #1;
            if ((k - c_LAT) >= 0 && (k - c_LAT) < n) begin
                check("stream_v", DQ_W'(out_v), DQ_W'(1));
                check("stream_data", out_data, mk(base + k - c_LAT));
            end else begin
                check("stream_idle_v", DQ_W'(out_v), DQ_W'(0));
            end
            tick();
        end
        in_v = 1'b0;
        #1;
        check("stream_end_count", DQ_W'(dq_count), DQ_W'(0));
        check("stream_end_v", DQ_W'(out_v), DQ_W'(0));
    endtask

    task automatic fill(input int n, input int base);
        rr_stall = 1'b1;
        for (int i = 0; i < n; i++) begin
            in_v    = 1'b1;
            in_data = mk(base + i);
            #1;
            check("fill_count", DQ_W'(dq_count), DQ_W'(i));
            tick();
        end
        in_v = 1'b0;
    endtask

    initial begin
        // Reset state
        #1;
        check("rst_count", DQ_W'(dq_count), DQ_W'(0));
        check("rst_v", DQ_W'(out_v), DQ_W'(0));
        check("rst_stall", DQ_W'(dq_stall), DQ_W'(0));
        @(negedge CLK);
        reset = 1'b1;
        tick();

        // A, B, C with RR free
        stream(3, 16'h0A00);

        // Fill with RR held, 5th refused, drain in order
        fill(4, 16'h0D00);
        in_v    = 1'b1;
        in_data = mk(16'h0E00);
        #1;
        check("full_count", DQ_W'(dq_count), DQ_W'(4));
        check("full_stall", DQ_W'(dq_stall), DQ_W'(1));
        tick();
        in_v     = 1'b0;
        rr_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("drain_v", DQ_W'(out_v), DQ_W'(1));
            check("drain_data", out_data, mk(16'h0D00 + i));
            if (i == 1) check("stall_drop", DQ_W'(dq_stall), DQ_W'(0));
            tick();
        end
        check("drain_end_v", DQ_W'(out_v), DQ_W'(0));
        check("drain_end_count", DQ_W'(dq_count), DQ_W'(0));

        // Full queue with simultaneous in_v and pop
        fill(4, 16'h0F00);
        rr_stall = 1'b0;
        in_v     = 1'b1;
        in_data  = mk(16'h0BAD);
        #1;
        check("fullpop_stall", DQ_W'(dq_stall), DQ_W'(1));
        check("fullpop_data", out_data, mk(16'h0F00));
        tick();
        in_v = 1'b0;
        #1;
        check("fullpop_count", DQ_W'(dq_count), DQ_W'(3));
        for (int i = 1; i < 4; i++) begin
            check("fullpop_drain", out_data, mk(16'h0F00 + i));
            tick();
        end
        check("fullpop_end_v", DQ_W'(out_v), DQ_W'(0));

        // Flush together with in_v
        fill(3, 16'h0100);
        in_v    = 1'b1;
        in_data = mk(16'h0FEE);
        flush   = 1'b1;
        #1;
        check("flush_v", DQ_W'(out_v), DQ_W'(0));
        tick();
        flush    = 1'b0;
        in_v     = 1'b0;
        rr_stall = 1'b0;
        #1;
        check("flush_count", DQ_W'(dq_count), DQ_W'(0));
        check("flush_after_v", DQ_W'(out_v), DQ_W'(0));
        tick();
        check("flush_absent_v", DQ_W'(out_v), DQ_W'(0));

        // Ten back-to-back entries through a four-deep queue
        stream(10, 16'h0200);

        // Empty queue, single in_v: bypass or one-cycle latency
        in_v    = 1'b1;
        in_data = mk(16'h0300);
        #1;
`ifdef DECODE_QUEUE_BYPASS_EN
        check("byp_v", DQ_W'(out_v), DQ_W'(1));
        check("byp_data", out_data, mk(16'h0300));
        tick();
        in_v = 1'b0;
        #1;
        check("byp_count", DQ_W'(dq_count), DQ_W'(0));
        check("byp_after_v", DQ_W'(out_v), DQ_W'(0));
`else
        check("lat_v0", DQ_W'(out_v), DQ_W'(0));
        tick();
        in_v = 1'b0;
        #1;
        check("lat_v1", DQ_W'(out_v), DQ_W'(1));
        check("lat_data", out_data, mk(16'h0300));
        check("lat_count", DQ_W'(dq_count), DQ_W'(1));
        tick();
`endif

        // Asynchronous reset mid-operation
        fill(2, 16'h0400);
        #1;
        reset = 1'b0;
        #1;
        check("arst_count", DQ_W'(dq_count), DQ_W'(0));
        check("arst_v", DQ_W'(out_v), DQ_W'(0));
        check("arst_stall", DQ_W'(dq_stall), DQ_W'(0));
        @(negedge CLK);
        reset    = 1'b1;
        rr_stall = 1'b0;
        tick();
        stream(2, 16'h0500);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
